// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls & Cows game controller and its scorer.
// Pure declarations: no logic, no latency, no flow control.
package bc_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;
  localparam int CODE_W  = DIGITS * DIGIT_W;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    SECRET_J1      = 3'd1,
    SECRET_J2      = 3'd2,
    GUESS_J1       = 3'd3,
    GUESS_J2       = 3'd4,
    WIN_J1         = 3'd5,
    WIN_J2         = 3'd6,
    DISPLAY_RESULT = 3'd7
  } state_t;

  typedef enum logic {
    J1 = 1'b0,
    J2 = 1'b1
  } player_t;

  // idx 0 is the rightmost digit; scoring is position-symmetric so order only matters for bulls.
  function automatic logic [DIGIT_W-1:0] digit(input logic [CODE_W-1:0] c, input int idx);
    return c[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/bc_scorer.sv
// Combinational Bulls & Cows scorer plus BCD/distinct-digit validity check of the guess.
// Zero latency, no flow control.
module bc_scorer
  import bc_pkg::*;
(
  input  logic [CODE_W-1:0] secret,
  input  logic [CODE_W-1:0] guess,
  output logic [2:0]        bulls,
  output logic [2:0]        cows,
  output logic              valid
);

  logic hit;

  always_comb begin
    bulls = '0;
    cows  = '0;
    valid = 1'b1;
    hit   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit(guess, i) > 4'd9) valid = 1'b0;
      if (digit(guess, i) == digit(secret, i)) bulls = bulls + 3'd1;
      hit = 1'b0;
      for (int j = 0; j < DIGITS; j++) begin
        if ((j != i) && (digit(guess, i) == digit(secret, j))) hit = 1'b1;
        if ((j > i) && (digit(guess, i) == digit(guess, j))) valid = 1'b0;
      end
      if (hit) cows = cows + 3'd1;
    end
  end

endmodule

// File: rtl/bc_game_controller.sv
// Two-player Bulls & Cows game FSM: secret capture, alternating scored guesses, timed result/win hold.
// Confirm press acts two edges after capture; no backpressure, extra presses in non-consuming states are dropped.
module bc_game_controller
  import bc_pkg::*;
#(
  parameter int unsigned RESULT_CYCLES = 100_000_000,
  parameter int unsigned WIN_CYCLES    = 300_000_000,
  parameter int unsigned TMR_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              confirm,
  input  logic [CODE_W-1:0] code,
  output logic [2:0]        current_state,
  output logic [3:0]        bulls,
  output logic [3:0]        cows,
  output logic [3:0]        wins_j1,
  output logic [3:0]        wins_j2,
  output logic              invalid
);

  localparam logic [TMR_W-1:0] RESULT_LAST = TMR_W'(RESULT_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYCLES - 1);

  state_t            state_q, state_d;
  player_t           next_player_q, next_player_d;
  logic [CODE_W-1:0] secret_j1_q, secret_j1_d;
  logic [CODE_W-1:0] secret_j2_q, secret_j2_d;
  logic [2:0]        bulls_q, bulls_d;
  logic [2:0]        cows_q, cows_d;
  logic [3:0]        wins_j1_q, wins_j1_d;
  logic [3:0]        wins_j2_q, wins_j2_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              invalid_q, invalid_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              tick;

  logic [CODE_W-1:0] score_secret;
  logic [2:0]        sc_bulls, sc_cows;
  logic              sc_valid;

  assign tick         = sync2_q & ~prev_q;
  assign score_secret = (state_q == GUESS_J1) ? secret_j2_q : secret_j1_q;

  bc_scorer u_scorer (
    .secret (score_secret),
    .guess  (code),
    .bulls  (sc_bulls),
    .cows   (sc_cows),
    .valid  (sc_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= confirm;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      next_player_q <= J1;
      secret_j1_q   <= '0;
      secret_j2_q   <= '0;
      bulls_q       <= '0;
      cows_q        <= '0;
      wins_j1_q     <= '0;
      wins_j2_q     <= '0;
      timer_q       <= '0;
      invalid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_player_q <= next_player_d;
      secret_j1_q   <= secret_j1_d;
      secret_j2_q   <= secret_j2_d;
      bulls_q       <= bulls_d;
      cows_q        <= cows_d;
      wins_j1_q     <= wins_j1_d;
      wins_j2_q     <= wins_j2_d;
      timer_q       <= timer_d;
      invalid_q     <= invalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    next_player_d = next_player_q;
    secret_j1_d   = secret_j1_q;
    secret_j2_d   = secret_j2_q;
    bulls_d       = bulls_q;
    cows_d        = cows_q;
    wins_j1_d     = wins_j1_q;
    wins_j2_d     = wins_j2_q;
    timer_d       = '0;
    invalid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        secret_j1_d = '0;
        secret_j2_d = '0;
        bulls_d     = '0;
        cows_d      = '0;
        if (tick) state_d = SECRET_J1;
      end
      SECRET_J1: begin
        if (tick) begin
          if (sc_valid) begin
            secret_j1_d = code;
            state_d     = SECRET_J2;
          end else begin
            invalid_d = 1'b1;
          end
        end
      end
      SECRET_J2: begin
        if (tick) begin
          if (sc_valid) begin
            secret_j2_d = code;
            state_d     = GUESS_J1;
          end else begin
            invalid_d = 1'b1;
          end
        end
      end
      GUESS_J1: begin
        if (tick) begin
          if (sc_valid) begin
            bulls_d = sc_bulls;
            cows_d  = sc_cows;
            if (sc_bulls == 3'd4) begin
              state_d = WIN_J1;
              if (wins_j1_q != 4'hF) wins_j1_d = wins_j1_q + 4'd1;
            end else begin
              state_d       = DISPLAY_RESULT;
              next_player_d = J2;
            end
          end else begin
            invalid_d = 1'b1;
          end
        end
      end
      GUESS_J2: begin
        if (tick) begin
          if (sc_valid) begin
            bulls_d = sc_bulls;
            cows_d  = sc_cows;
            if (sc_bulls == 3'd4) begin
              state_d = WIN_J2;
              if (wins_j2_q != 4'hF) wins_j2_d = wins_j2_q + 4'd1;
            end else begin
              state_d       = DISPLAY_RESULT;
              next_player_d = J1;
            end
          end else begin
            invalid_d = 1'b1;
          end
        end
      end
      DISPLAY_RESULT: begin
        timer_d = timer_q + TMR_W'(1);
        if (tick || (timer_q == RESULT_LAST))
          state_d = (next_player_q == J1) ? GUESS_J1 : GUESS_J2;
      end
      WIN_J1, WIN_J2: begin
        timer_d = timer_q + TMR_W'(1);
        if (tick || (timer_q == WIN_LAST)) begin
          state_d     = IDLE;
          secret_j1_d = '0;
          secret_j2_d = '0;
          bulls_d     = '0;
          cows_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any state change restarts the hold timer so each timed state counts from zero.
    if (state_d != state_q) timer_d = '0;
  end

  assign current_state = state_q;
  assign bulls         = {1'b0, bulls_q};
  assign cows          = {1'b0, cows_q};
  assign wins_j1       = wins_j1_q;
  assign wins_j2       = wins_j2_q;
  assign invalid       = invalid_q;

endmodule

// File: doc/bc_game_controller.md
Name: bc_game_controller

Overview:
Central game FSM for the two-player Bulls & Cows design. It captures both secrets from the switch code and validates every entry. It scores each guess against the opponent's secret and sequences the game through secret entry, alternating guesses, result display and win phases. Its outputs drive the display manager: state, bulls, cows, and per-player win counters.

Parameters:
RESULT_CYCLES, 100_000_000, cycles DISPLAY_RESULT is held before auto-advance (1 s at 100 MHz)
WIN_CYCLES, 300_000_000, cycles WIN_Jx is held before auto-return to IDLE
TMR_W, 32, width of shared hold timer; must hold max(RESULT_CYCLES, WIN_CYCLES)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
confirm  input  1  raw confirm pushbutton, asynchronous to clock
code  input  16  four BCD digits; code[15:12] is the leftmost digit
current_state  output  3  state_t encoding of the FSM state
bulls  output  4  bulls of the last scored guess, 0..4
cows  output  4  cows of the last scored guess, 0..4
wins_j1  output  4  games won by J1, saturating at 15
wins_j2  output  4  games won by J2, saturating at 15
invalid  output  1  one-cycle pulse when a confirmed code is rejected

Behaviour:
- Reset (reset=0, async): state=IDLE; bulls=cows=wins_j1=wins_j2=0; invalid=0; secrets=0; timer=0; sync/edge flops=0.
- confirm path: 2-FF synchronizer, then rising-edge detect gives tick (sync2 & ~prev).
- Confirm latency: for a press meeting setup before edge N, state updates at edge N+2. Holding confirm produces one tick only.
- Code validation (valid): every nibble ≤ 9 AND all four nibbles pairwise distinct.
- Encoding: IDLE=0, SECRET_J1=1, SECRET_J2=2, GUESS_J1=3, GUESS_J2=4, WIN_J1=5, WIN_J2=6, DISPLAY_RESULT=7.
- IDLE: on tick go to SECRET_J1; secrets, bulls and cows are cleared on IDLE entry.
- SECRET_J1: on tick, if valid, store secret_j1 (the secret J2 must find) and go to SECRET_J2; if not valid, pulse invalid and stay.
- SECRET_J2: same as SECRET_J1, storing secret_j2, then go to GUESS_J1.
- GUESS_J1: on tick with a valid code, score it against secret_j2 and register bulls/cows.
  - If bulls=4: go to WIN_J1 and increment wins_j1 (saturating).
  - Otherwise: go to DISPLAY_RESULT with next_player=J2.
  - Invalid code: pulse invalid, bulls/cows unchanged, stay.
- GUESS_J2: mirror of GUESS_J1, scoring against secret_j1 and leading to WIN_J2 / next_player=J1.
- DISPLAY_RESULT: timer loads 0 on entry and counts up.
  - Leave on timer = RESULT_CYCLES-1 or on tick, whichever comes first, going to GUESS of next_player.
  - Timer expiry and tick in the same cycle cause one transition only.
- WIN_J1 / WIN_J2: timer restarts on entry; leave on timer = WIN_CYCLES-1 or on tick, going to IDLE.
- bulls/cows hold their last value through DISPLAY_RESULT, WIN states and the next GUESS state, until rescored or cleared.
- invalid is asserted only in SECRET/GUESS states, in the cycle after the rejecting tick's edge, for exactly one cycle.
- A code change without a tick has no effect. Ticks in states that do not consume them (none besides those listed) are ignored.
- Reset mid-game: all state is lost immediately, including win counters.

Decomposition:
- Package bc_pkg: state_t enum with the explicit 3-bit encoding above; DIGITS=4; DIGIT_W=4; player_t (J1, J2).
- Sub-module bc_scorer (purely combinational):
  - Inputs: secret[15:0], guess[15:0].
  - Outputs: bulls[2:0], cows[2:0], valid.
  - bulls = count of equal nibbles at the same position.
  - cows = count of guess digits present in secret at a different position.
  - valid applies to guess only; the controller reuses it for secret entry.
- Controller zero-extends bulls/cows to 4 bits.

Test Plan:
- Reset, tick, enter 16'h1234 (tick), enter 16'h5678 (tick) -> states 0→1→2→3; invalid never asserted.
- In GUESS_J1 (secret_j2=5678) enter 16'h5687 + tick -> bulls=2, cows=2, state=7; after RESULT_CYCLES (set 8 in sim) state=4.
- In GUESS_J2 (secret_j1=1234) enter 16'h1234 + tick -> bulls=4, state=5→no; state=6 (WIN_J2), wins_j2=1; tick -> state=0, bulls=cows=0.
- In SECRET_J1 enter 16'h1123 + tick, then 16'h12A4 + tick -> two single-cycle invalid pulses, state stays 1, secret not stored.
- Confirm held high 50 cycles in IDLE -> exactly one transition to 1. Tick landing on the timer-expiry cycle in DISPLAY_RESULT -> single move to GUESS, not past it.
- Assert reset asynchronously mid-cycle in DISPLAY_RESULT with wins_j1=3 -> outputs zero immediately, state=0 without a clock edge.
